uart_rx_fifo: RTL and testbench

- Parametrised UART receiver with an integrated receive FIFO; successor to the bare uart shell.
- Generalises data width, parity mode, stop-bit count, baud divisor and buffer depth.
- Adds error flagging and sticky overflow; delivers words to the core over a valid/ready read port.
- Sits between the rxd pin and any bus-side consumer.

---
 rtl/uart_pkg.sv | 17 +
 rtl/sync_fifo.sv | 53 +++++
 rtl/uart_rx_fifo.sv | 168 ++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART receive path: parity modes, receiver states and the stored word layout.
package uart_pkg;

  typedef enum logic [1:0] {PAR_NONE, PAR_ODD, PAR_EVEN} parity_e;

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} rx_state_e;

  localparam int MAX_DATA_BITS = 9;

  // Sized for the widest frame; narrower configurations leave the top data bits at zero
  typedef struct packed {
    logic                     frame_err;
    logic                     parity_err;
    logic [MAX_DATA_BITS-1:0] data;
  } rx_word_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count and full/empty flags.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [WIDTH-1:0]               wr_data,
  input  logic                           rd_en,
  output logic [WIDTH-1:0]               rd_data,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full,
  output logic                           empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = rd_en && !empty;
  // A write into a full FIFO is only taken when the head leaves in the same cycle
  assign do_push = wr_en && (!full || do_pop);
  assign count   = count_q;
  assign rd_data = empty ? '0 : mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver: synchronised rxd, mid-bit sampling FSM with parity/frame checks, feeding a FWFT FIFO.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_DIV     = 16,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int BUFFER_SIZE = 1024
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 rxd,
  output logic                                 rd_valid,
  input  logic                                 rd_ready,
  output logic [DATA_BITS-1:0]                 rd_data,
  output logic                                 rd_parity_err,
  output logic                                 rd_frame_err,
  output logic [$clog2(BUFFER_SIZE+1)-1:0]     count,
  output logic                                 overflow,
  input  logic                                 overflow_clr
);

  localparam int            TW        = $clog2(CLK_DIV);
  localparam logic [TW-1:0] T_LAST    = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] T_MID     = TW'(CLK_DIV / 2 - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam parity_e       PAR_MODE  = parity_e'(PARITY);
  localparam int            WW        = DATA_BITS + 2;

  logic                 rx_meta, rxs;
  rx_state_e            state_q, state_n;
  logic [TW-1:0]        timer_q, timer_n;
  logic [3:0]           bit_q, bit_n;
  logic [DATA_BITS-1:0] shift_q, shift_n;
  logic                 perr_q, perr_n, ferr_q, ferr_n;
  logic                 bit_tick, push, pop, fifo_full, fifo_empty;
  logic                 overflow_q, unused_pad;
  rx_word_t             push_word;
  logic [WW-1:0]        fifo_wdata, fifo_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      timer_q <= timer_n;
      bit_q   <= bit_n;
      shift_q <= shift_n;
      perr_q  <= perr_n;
      ferr_q  <= ferr_n;
    end
  end

  // The timer is re-zeroed at mid-start, so every later tick at T_LAST lands mid-bit
  assign bit_tick = (timer_q == T_LAST);

  always_comb begin
    state_n = state_q;
    timer_n = bit_tick ? '0 : timer_q + 1'b1;
    bit_n   = bit_q;
    shift_n = shift_q;
    perr_n  = perr_q;
    ferr_n  = ferr_q;
    push    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        timer_n = '0;
        bit_n   = '0;
        perr_n  = 1'b0;
        ferr_n  = 1'b0;
        if (!rxs) state_n = ST_START;
      end
      ST_START: begin
        if (timer_q == T_MID) begin
          timer_n = '0;
          state_n = rxs ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          shift_n = {rxs, shift_q[DATA_BITS-1:1]};
          if (bit_q == DATA_LAST) begin
            bit_n   = '0;
            state_n = (PAR_MODE == PAR_NONE) ? ST_STOP : ST_PARITY;
          end else begin
            bit_n = bit_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_tick) begin
          perr_n  = ((^shift_q) ^ rxs) != (PAR_MODE == PAR_ODD);
          state_n = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_tick) begin
          ferr_n = ferr_q | ~rxs;
          // Leaving at mid-stop leaves half a bit of margin to catch a back-to-back start edge
          if (bit_q == STOP_LAST) begin
            push    = 1'b1;
            state_n = ST_IDLE;
          end else begin
            bit_n = bit_q + 1'b1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    push_word                      = '0;
    push_word.frame_err            = ferr_n;
    push_word.parity_err           = perr_q;
    push_word.data[DATA_BITS-1:0]  = shift_q;
  end

  assign fifo_wdata = {push_word.frame_err, push_word.parity_err, push_word.data[DATA_BITS-1:0]};
  assign unused_pad = ^push_word.data;

  assign rd_valid      = !fifo_empty;
  assign pop           = rd_valid && rd_ready;
  assign rd_data       = fifo_rdata[DATA_BITS-1:0];
  assign rd_parity_err = fifo_rdata[DATA_BITS];
  assign rd_frame_err  = fifo_rdata[DATA_BITS+1];
  assign overflow      = overflow_q;

  sync_fifo #(
    .WIDTH (WW),
    .DEPTH (BUFFER_SIZE)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (fifo_wdata),
    .rd_en   (pop),
    .rd_data (fifo_rdata),
    .count   (count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // A new drop takes priority over a clear arriving in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              overflow_q <= 1'b0;
    else if (push && fifo_full && !pop)   overflow_q <= 1'b1;
    else if (overflow_clr)                overflow_q <= 1'b0;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: one even-parity/1-stop instance and one no-parity/2-stop instance.
module tb_uart_rx_fifo;

  localparam int CLK_DIV = 16;
  // 2 sync flops + IDLE detect, half a bit to mid-start, then 8 data + (parity or 2nd stop) + stop
  localparam int EXP_LAT = 3 + CLK_DIV / 2 + CLK_DIV * 10;
  localparam int MAX_WAIT = 400;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd_a = 1'b1, rxd_b = 1'b1;
  logic       rd_ready_a = 1'b0, rd_ready_b = 1'b0;
  logic       overflow_clr_a = 1'b0, overflow_clr_b = 1'b0;
  logic       rd_valid_a, rd_valid_b;
  logic [7:0] rd_data_a, rd_data_b;
  logic       perr_a, perr_b, ferr_a, ferr_b;
  logic [2:0] count_a, count_b;
  logic       overflow_a, overflow_b;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       sel;
    logic [7:0] data;
    logic       par_bit;
    logic       s0;
    logic       s1;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .CLK_DIV(CLK_DIV), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .BUFFER_SIZE(4)
  ) dut_a (
    .clk(clk), .rst(rst), .rxd(rxd_a), .rd_valid(rd_valid_a), .rd_ready(rd_ready_a),
    .rd_data(rd_data_a), .rd_parity_err(perr_a), .rd_frame_err(ferr_a),
    .count(count_a), .overflow(overflow_a), .overflow_clr(overflow_clr_a)
  );

  uart_rx_fifo #(
    .CLK_DIV(CLK_DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .BUFFER_SIZE(4)
  ) dut_b (
    .clk(clk), .rst(rst), .rxd(rxd_b), .rd_valid(rd_valid_b), .rd_ready(rd_ready_b),
    .rd_data(rd_data_b), .rd_parity_err(perr_b), .rd_frame_err(ferr_b),
    .count(count_b), .overflow(overflow_b), .overflow_clr(overflow_clr_b)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic sel, input logic b);
    if (sel) rxd_b = b;
    else     rxd_a = b;
    repeat (CLK_DIV) @(posedge clk);
    #1;
  endtask

  // Instance A frames carry a parity bit and one stop; instance B frames carry two stops
  task automatic send_frame(input logic sel, input logic [7:0] data, input logic par_bit,
                            input logic s0, input logic s1);
    drive_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(sel, data[i]);
    if (!sel) drive_bit(sel, par_bit);
    drive_bit(sel, s0);
    if (sel) drive_bit(sel, s1);
  endtask

  task automatic apply_stimulus(input vec_t v);
    send_frame(v.sel, v.data, v.par_bit, v.s0, v.s1);
    if (sel_is_b(v)) rxd_b = 1'b1;
    else             rxd_a = 1'b1;
  endtask

  function automatic logic sel_is_b(input vec_t v);
    return v.sel;
  endfunction

  task automatic wait_valid(input logic sel, output int lat);
    lat = 0;
    while (lat < MAX_WAIT) begin
      @(negedge clk);
      if ((sel ? rd_valid_b : rd_valid_a) === 1'b1) break;
      lat++;
    end
  endtask

  task automatic pop_word(input logic sel);
    @(posedge clk); #1;
    if (sel) rd_ready_b = 1'b1;
    else     rd_ready_a = 1'b1;
    @(posedge clk); #1;
    rd_ready_a = 1'b0;
    rd_ready_b = 1'b0;
  endtask

  initial begin
    int lat;
    logic [7:0] b;

    vecs[0] = '{1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'h3C, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 8'h01, 1'b1, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 8'h81, 1'b0, 1'b1, 1'b0, 8'h81, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 8'h81, 1'b0, 1'b1, 1'b1, 8'h81, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 8'h7E, 1'b0, 1'b0, 1'b1, 8'h7E, 1'b0, 1'b1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("reset rd_valid_a", rd_valid_a, 0);
    check_output("reset rd_data_a",  rd_data_a, 0);
    check_output("reset count_a",    count_a, 0);
    check_output("reset overflow_a", overflow_a, 0);
    check_output("reset flags_a",    {perr_a, ferr_a}, 0);
    check_output("reset rd_valid_b", rd_valid_b, 0);
    check_output("reset count_b",    count_b, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    $display("[TB] single-frame vectors");
    for (int i = 0; i < 8; i++) begin
      fork
        apply_stimulus(vecs[i]);
        wait_valid(vecs[i].sel, lat);
      join
      check_output("latency", lat, EXP_LAT);
      @(negedge clk);
      check_output("rd_data", vecs[i].sel ? rd_data_b : rd_data_a, vecs[i].exp_data);
      check_output("parity_err", vecs[i].sel ? perr_b : perr_a, vecs[i].exp_perr);
      check_output("frame_err", vecs[i].sel ? ferr_b : ferr_a, vecs[i].exp_ferr);
      check_output("count one", vecs[i].sel ? count_b : count_a, 1);
      pop_word(vecs[i].sel);
      @(negedge clk);
      check_output("count after pop", vecs[i].sel ? count_b : count_a, 0);
      repeat (2 * CLK_DIV) @(posedge clk);
      #1;
    end

    $display("[TB] short low pulse");
    rxd_a = 1'b0;
    repeat (4) @(posedge clk);
    #1 rxd_a = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    check_output("glitch count", count_a, 0);
    check_output("glitch rd_valid", rd_valid_a, 0);
    @(posedge clk); #1;

    $display("[TB] overflow with back-to-back frames");
    for (int i = 1; i <= 5; i++) begin
      b = 8'(i);
      send_frame(1'b0, b, ^b, 1'b1, 1'b1);
    end
    @(negedge clk);
    check_output("full count", count_a, 4);
    check_output("overflow set", overflow_a, 1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check_output("fifo order", rd_data_a, i);
      pop_word(1'b0);
    end
    @(negedge clk);
    check_output("drained count", count_a, 0);
    check_output("drained rd_valid", rd_valid_a, 0);
    check_output("overflow sticky", overflow_a, 1);
    @(posedge clk); #1;
    overflow_clr_a = 1'b1;
    @(posedge clk); #1;
    overflow_clr_a = 1'b0;
    @(negedge clk);
    check_output("overflow cleared", overflow_a, 0);
    @(posedge clk); #1;

    $display("[TB] reset during a frame");
    send_frame(1'b0, 8'h11, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    check_output("pre-reset count", count_a, 1);
    @(posedge clk); #1;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b0, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check_output("mid reset rd_valid", rd_valid_a, 0);
    check_output("mid reset rd_data",  rd_data_a, 0);
    check_output("mid reset count",    count_a, 0);
    check_output("mid reset flags",    {perr_a, ferr_a, overflow_a}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    send_frame(1'b0, 8'h55, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    check_output("post-reset count", count_a, 1);
    check_output("post-reset data",  rd_data_a, 8'h55);
    check_output("post-reset flags", {perr_a, ferr_a}, 0);
    pop_word(1'b0);
    @(negedge clk);
    check_output("post-reset drained", count_a, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
